// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I load/store unit: XLEN, funct3 width/sign
// encodings, the LSU state enum, the access-size enum, and small helpers
// that decode funct3 into an access size and flag encodings outside the
// load/store set.
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} lsu_state_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

    // Any encoding that is not a byte or half access falls back to a word
    // access. This is how bad funct3 values behave when they are not trapped.
    function automatic lsu_size_e f3_size(input logic store, input logic [2:0] f3);
        if (f3 == F3_B || (!store && f3 == F3_BU)) return SZ_B;
        if (f3 == F3_H || (!store && f3 == F3_HU)) return SZ_H;
        return SZ_W;
    endfunction

    // Stores have no unsigned variants, so BU/HU are also bad on a store.
    function automatic logic f3_bad(input logic store, input logic [2:0] f3);
        if (store) return !(f3 inside {F3_B, F3_H, F3_W});
        return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/lsu_align_rv32i.sv
// ---------------------------------------------------------------------------
// lsu_align_rv32i
// Purely combinational lane logic for the RV32I LSU.
//   Store path: funct3 + address offset -> byte strobes and replicated data.
//   Load path : funct3 + address offset + read word -> sign/zero extended data.
// Optional macro LSU_MISALIGN_TRAP_EN:
//   defined   - misaligned half/word accesses are flagged on 'misaligned'.
//   undefined - they are aligned down (half: off & 2'b10, word: off = 0)
//               and 'misaligned' is tied to 0.
// Ports:
//   store      in   1 = store access, 0 = load access
//   funct3     in   RV32I width/sign field
//   off        in   address bits [1:0]
//   wdata      in   rs2 store data
//   rdata      in   word read from memory
//   wstrb      out  byte-lane strobes for a store
//   wdata_lane out  store data replicated onto the active lanes
//   rdata_ext  out  extracted and extended load data
//   misaligned out  access violates natural alignment (trap build only)
// ---------------------------------------------------------------------------
module lsu_align_rv32i
    import rv32i_pkg::*;
(
    input  logic            store,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata_lane,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misaligned
);

    lsu_size_e  size;
    logic [1:0] eff_off;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        size       = f3_size(store, funct3);
        eff_off    = off;
        misaligned = 1'b0;
        wstrb      = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;

        case (size)
            SZ_H: begin
`ifdef LSU_MISALIGN_TRAP_EN
                misaligned = off[0];
`else
                eff_off = {off[1], 1'b0};
`endif
            end
            SZ_W: begin
`ifdef LSU_MISALIGN_TRAP_EN
                misaligned = (off != 2'b00);
`else
                eff_off = 2'b00;
`endif
            end
            default: ;
        endcase

        byte_sel = rdata[{eff_off, 3'b000} +: 8];
        half_sel = rdata[{eff_off[1], 4'b0000} +: 16];

        // funct3[2] distinguishes the unsigned loads (BU/HU).
        case (size)
            SZ_B: begin
                wstrb      = 4'b0001 << eff_off;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                wstrb      = 4'b0011 << eff_off;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_rv32i.sv
// ---------------------------------------------------------------------------
// lsu_rv32i
// RV32I load/store unit sitting after the ALU adder. Accepts one request,
// issues a single word-aligned memory transaction with byte strobes, waits
// for mem_ack (bounded by TIMEOUT_CYCLES) and returns extended load data.
// The core stalls while req_ready is low; there is no back-to-back issue.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses give
// an error response instead of being aligned down.
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycles to wait for mem_ack (1..65535)
//   ERR_ON_BAD_F3   1: unknown funct3 errors; 0: treated as a word access
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   req_valid/req_ready                 request handshake
//   req_store, req_funct3, req_addr,
//   req_wdata                           request payload
//   mem_req, mem_we, mem_addr,
//   mem_wstrb, mem_wdata                memory request (held during BUSY)
//   mem_ack, mem_rdata                  memory completion and read word
//   rsp_valid, rsp_rdata, rsp_err       one-cycle response
// ---------------------------------------------------------------------------
module lsu_rv32i
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          ERR_ON_BAD_F3  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state;
    logic [15:0] cnt;
    logic        cap_store;
    logic [2:0]  cap_f3;
    logic [1:0]  cap_off;

    // One aligner serves both paths: in IDLE it sees the incoming request
    // (store lanes, alignment check); afterwards it sees the captured request
    // so the load path can extract from mem_rdata.
    logic            al_store;
    logic [2:0]      al_f3;
    logic [1:0]      al_off;
    logic [3:0]      al_wstrb;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;
    logic            al_misaligned;
    logic            req_legal;

    assign al_store = (state == IDLE) ? req_store     : cap_store;
    assign al_f3    = (state == IDLE) ? req_funct3    : cap_f3;
    assign al_off   = (state == IDLE) ? req_addr[1:0] : cap_off;

    lsu_align_rv32i u_align (
        .store      (al_store),
        .funct3     (al_f3),
        .off        (al_off),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .wstrb      (al_wstrb),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata),
        .misaligned (al_misaligned)
    );

    assign req_legal = !(ERR_ON_BAD_F3 && f3_bad(req_store, req_funct3)) && !al_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_store <= 1'b0;
            cap_f3    <= '0;
            cap_off   <= '0;
            req_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_store <= req_store;
                        cap_f3    <= req_funct3;
                        cap_off   <= req_addr[1:0];
                        req_ready <= 1'b0;
                        if (req_legal) begin
                            state     <= BUSY;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                            mem_wstrb <= req_store ? al_wstrb : 4'b0000;
                            mem_wdata <= req_store ? al_wdata : '0;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    // Ack is tested first so it wins over a saturating counter.
                    if (mem_ack || cnt == CNT_LAST) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wstrb <= '0;
                        mem_wdata <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !mem_ack;
                        rsp_rdata <= (mem_ack && !cap_store) ? al_rdata : '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
